decode_stage: RTL and testbench
===============================

# decode_stage

Registered instruction-decode pipeline stage for the RV32I core. It wraps the team's combinational control decode in a valid/ready pipeline register and detects load-use hazards, inserting one bubble per hazard. It supports optional M-extension decode, flags illegal opcodes, and keeps a stall counter. It sits between the fetch/IF-ID register and the execute stage, replacing the unregistered control path.

## Interface
- `XLEN`, 32: PC width.
- `ENABLE_M`, 0: 1 = decode OP with funct7=0000001 as mul/div (`muldiv`=1); 0 = such encodings are illegal.
- `CNT_W`, 16: width of the stall counter.

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `in_valid`  in  1  fetch presents an instruction.
- `in_ready`  out  1  stage accepts it this cycle.
- `in_instr`  in  32  instruction word.
- `in_pc`  in  XLEN  its PC.
- `flush`  in  1  squash the held and incoming instruction (taken branch/jump).
- `out_valid`  out  1  registered bundle valid.
- `out_ready`  in  1  execute consumes the bundle.
- `out_pc`, `out_instr`  out  XLEN/32  registered copies.
- `out_rd`, `out_rs1`, `out_rs2`  out  5 each  register fields.
- `alusrc` out 2; `memtoreg` out 1; `regwrite` out 1; `memwrite` out 4; `branch` out 3; `aluop` out 2; `regin` out 2; `imm` out 3: the registered control bundle.
- `muldiv`  out  1  M-extension operation.
- `illegal`  out  1  unrecognised opcode/funct.
- `stall_cnt`  out  CNT_W  saturating count of hazard bubbles.

## Operation
- Decode table, unchanged from the existing control encoding:
  - `branch`: BEQ/BGE/BGEU=010, BNE/BLT/BLTU=001, JAL=011, JALR=100, else 000.
  - `memwrite`: SW=1111, SH=0011, SB=0001.
  - `memtoreg`: loads.
  - `regwrite`: OP, LOAD, OP-IMM, JAL, JALR, AUIPC, LUI.
  - `alusrc[0]`: STORE, LOAD, OP-IMM, AUIPC, JALR; `alusrc[1]`: AUIPC.
  - `aluop[1]`: OP, OP-IMM; `aluop[0]`: BRANCH.
  - `regin`: LUI=00, JAL/JALR=10, else 01.
  - `imm`: S=001, U=010, J=011, B=100, LBU/LHU=101, else 000.
- Illegal handling:
  - Illegal cases: opcode outside the nine above, branch funct3 010/011, store funct3 not in {000,001,010}.
  - On illegal: `illegal`=1 and `regwrite`, `memwrite`, `branch`, `muldiv` forced 0.
- Source-use rules:
  - rs1 is used by all legal opcodes except LUI, AUIPC, JAL.
  - rs2 is used by OP, STORE, BRANCH.
- Hazard condition: `hz` = `out_valid` & `memtoreg` & `out_rd`≠0 & `in_valid` & (rs1 used & rs1==`out_rd` | rs2 used & rs2==`out_rd`).
- `in_ready` = !`flush` & !`hz` & (!`out_valid` | `out_ready`).
- Register update priority:
  - `flush` → `out_valid`←0.
  - Else if `in_valid` & `in_ready` → load the decoded bundle, `out_valid`←1.
  - Else if `out_ready` → `out_valid`←0. This includes the hazard case, which inserts the bubble.
  - Else hold.
- Counter: `stall_cnt` increments on each cycle with `hz` & `out_ready` & !`flush`; it saturates at all-ones.

## Timing
- Latency is 1 cycle from accepted input to `out_valid`; throughput is 1 instruction/cycle with no hazards.
- Reset values: `out_valid`=0, `stall_cnt`=0, every bundle/field/PC output 0. Reset mid-operation discards the held instruction immediately (asynchronous).
- While `out_valid` & !`out_ready`, all outputs hold stable.
- Each load-use pair costs exactly one bubble. The hazard clears the following cycle because `out_valid`=0.
- `flush` together with `in_valid`: the input is not accepted and `out_valid`=0 on the next cycle.
- `flush` during a hazard: the flush wins and no stall is counted.
- Bundle fields while `out_valid`=0 are don't-care to the consumer, but the implementation clears them for waveform clarity.

## Structure
- Shared package `rv_decode_pkg` holds:
  - opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC);
  - the `branch`/`imm`/`regin` encoding constants;
  - a packed `ctrl_t` struct for the bundle.
- Sub-module `decode_comb` holds the pure combinational decode (instr → `ctrl_t`, rs-used flags, illegal), parametrised by `ENABLE_M`. `decode_stage` holds the handshake, hazard logic, register and counter.

## Test plan
- Back-to-back ADDI x1,x0,5 / SW x1,8(x2) with `out_ready`=1 → two consecutive `out_valid` cycles. The SW has `memwrite`=1111, `imm`=001, `alusrc`=01.
- LW x5,0(x1) then ADD x6,x5,x7 → `in_ready`=0 for one cycle, one bubble, `stall_cnt`=1, then the ADD issues. Repeat with rd=x0 → no bubble.
- `out_ready`=0 for 3 cycles with a JAL held → outputs stable (`branch`=011, `regin`=10), `in_ready`=0, no input lost.
- `flush` with `in_valid`=1 and a valid held instruction → `out_valid`=0 next cycle and the incoming instruction is dropped.
- MUL x1,x2,x3 (funct7=0000001): `ENABLE_M`=1 → `muldiv`=1, `aluop`=10. `ENABLE_M`=0 → `illegal`=1, `regwrite`=0. Opcode 0000000 → `illegal`=1.
- Assert `reset` mid-stream while `out_valid`=1 → all outputs 0 immediately. Force `stall_cnt` near max (`CNT_W`=2) with repeated hazards → saturates at 3.

Source files
------------

// File: rtl/rv_decode_pkg.sv
// Shared decode definitions: RV32I opcodes, control encodings and the
// registered control bundle carried from decode into execute.
package rv_decode_pkg;

    // Major opcodes recognised by the decoder
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // funct7 value that marks an M-extension operation under OP
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;

    // branch field encodings
    localparam logic [2:0] BR_NONE    = 3'b000;
    localparam logic [2:0] BR_NE_LT   = 3'b001;  // BNE, BLT, BLTU
    localparam logic [2:0] BR_EQ_GE   = 3'b010;  // BEQ, BGE, BGEU
    localparam logic [2:0] BR_JAL     = 3'b011;
    localparam logic [2:0] BR_JALR    = 3'b100;

    // immediate format encodings
    localparam logic [2:0] IMM_I      = 3'b000;
    localparam logic [2:0] IMM_S      = 3'b001;
    localparam logic [2:0] IMM_U      = 3'b010;
    localparam logic [2:0] IMM_J      = 3'b011;
    localparam logic [2:0] IMM_B      = 3'b100;
    localparam logic [2:0] IMM_LU     = 3'b101;  // zero-extending loads

    // register write-back source encodings
    localparam logic [1:0] REGIN_LUI  = 2'b00;
    localparam logic [1:0] REGIN_ALU  = 2'b01;
    localparam logic [1:0] REGIN_PC4  = 2'b10;

    typedef struct packed {
        logic [1:0] alusrc;
        logic       memtoreg;
        logic       regwrite;
        logic [3:0] memwrite;
        logic [2:0] branch;
        logic [1:0] aluop;
        logic [1:0] regin;
        logic [2:0] imm;
        logic       muldiv;
        logic       illegal;
    } ctrl_t;

    // Byte-lane mask for a store width; zero marks an unsupported width
    function automatic logic [3:0] store_mask(input logic [2:0] funct3);
        case (funct3)
            3'b000:  store_mask = 4'b0001;
            3'b001:  store_mask = 4'b0011;
            3'b010:  store_mask = 4'b1111;
            default: store_mask = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/decode_stage_comb.sv
// Pure combinational RV32I control decode: instruction word to control
// bundle, source-register usage flags and illegal-instruction flag.
module decode_comb
    import rv_decode_pkg::*;
#(
    parameter int ENABLE_M = 0
) (
    input  logic [31:0] instr,
    output ctrl_t       ctrl,
    output logic        rs1_used,
    output logic        rs2_used
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    // Decode table; illegal encodings have every side effect suppressed
    always_comb begin
        ctrl       = '0;
        ctrl.regin = REGIN_ALU;
        rs1_used   = 1'b0;
        rs2_used   = 1'b0;
        case (opcode)
            OPC_OP: begin
                ctrl.regwrite = 1'b1;
                ctrl.aluop    = 2'b10;
                if (funct7 == F7_MULDIV) begin
                    if (ENABLE_M != 0) ctrl.muldiv  = 1'b1;
                    else               ctrl.illegal = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                ctrl.regwrite = 1'b1;
                ctrl.alusrc   = 2'b01;
                ctrl.aluop    = 2'b10;
            end
            OPC_LOAD: begin
                ctrl.memtoreg = 1'b1;
                ctrl.regwrite = 1'b1;
                ctrl.alusrc   = 2'b01;
                if (funct3 == 3'b100 || funct3 == 3'b101) ctrl.imm = IMM_LU;
                else                                      ctrl.imm = IMM_I;
            end
            OPC_STORE: begin
                ctrl.alusrc   = 2'b01;
                ctrl.imm      = IMM_S;
                ctrl.memwrite = store_mask(funct3);
                if (store_mask(funct3) == 4'b0000) ctrl.illegal = 1'b1;
            end
            OPC_BRANCH: begin
                ctrl.aluop = 2'b01;
                ctrl.imm   = IMM_B;
                case (funct3)
                    3'b000, 3'b101, 3'b111: ctrl.branch  = BR_EQ_GE;
                    3'b001, 3'b100, 3'b110: ctrl.branch  = BR_NE_LT;
                    default:                ctrl.illegal = 1'b1;
                endcase
            end
            OPC_JAL: begin
                ctrl.regwrite = 1'b1;
                ctrl.branch   = BR_JAL;
                ctrl.regin    = REGIN_PC4;
                ctrl.imm      = IMM_J;
            end
            OPC_JALR: begin
                ctrl.regwrite = 1'b1;
                ctrl.branch   = BR_JALR;
                ctrl.regin    = REGIN_PC4;
                ctrl.alusrc   = 2'b01;
            end
            OPC_LUI: begin
                ctrl.regwrite = 1'b1;
                ctrl.regin    = REGIN_LUI;
                ctrl.imm      = IMM_U;
            end
            OPC_AUIPC: begin
                ctrl.regwrite = 1'b1;
                ctrl.alusrc   = 2'b11;
                ctrl.imm      = IMM_U;
            end
            default: ctrl.illegal = 1'b1;
        endcase

        if (ctrl.illegal) begin
            ctrl.regwrite = 1'b0;
            ctrl.memwrite = 4'b0000;
            ctrl.branch   = BR_NONE;
            ctrl.muldiv   = 1'b0;
        end

        rs1_used = !ctrl.illegal && (opcode != OPC_LUI) &&
                   (opcode != OPC_AUIPC) && (opcode != OPC_JAL);
        rs2_used = (opcode == OPC_OP) || (opcode == OPC_STORE) ||
                   (opcode == OPC_BRANCH);
    end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: control decode behind a valid/ready pipeline
// register, load-use hazard bubble insertion and a saturating stall count.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready never depends on in_valid except through the hazard
// check, and out_valid with its bundle stays stable until out_ready.
module decode_stage
    import rv_decode_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int ENABLE_M = 0,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [31:0]      out_instr,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [1:0]       alusrc,
    output logic             memtoreg,
    output logic             regwrite,
    output logic [3:0]       memwrite,
    output logic [2:0]       branch,
    output logic [1:0]       aluop,
    output logic [1:0]       regin,
    output logic [2:0]       imm,
    output logic             muldiv,
    output logic             illegal,
    output logic [CNT_W-1:0] stall_cnt
);

    ctrl_t dec_ctrl;
    ctrl_t q_ctrl;
    logic  dec_rs1_used;
    logic  dec_rs2_used;
    logic  hz;

    decode_comb #(.ENABLE_M(ENABLE_M)) u_decode (
        .instr    (in_instr),
        .ctrl     (dec_ctrl),
        .rs1_used (dec_rs1_used),
        .rs2_used (dec_rs2_used)
    );

    // Load-use hazard against the held load, and the resulting input ready
    always_comb begin
        hz = out_valid && q_ctrl.memtoreg && (out_rd != 5'd0) && in_valid &&
             ((dec_rs1_used && (in_instr[19:15] == out_rd)) ||
              (dec_rs2_used && (in_instr[24:20] == out_rd)));
        in_ready = !flush && !hz && (!out_valid || out_ready);
    end

    // Pipeline register; an emptied slot is zeroed so idle fields read 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            q_ctrl    <= '0;
            out_pc    <= '0;
            out_instr <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            q_ctrl    <= '0;
            out_pc    <= '0;
            out_instr <= '0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            q_ctrl    <= dec_ctrl;
            out_pc    <= in_pc;
            out_instr <= in_instr;
        end else if (out_ready) begin
            out_valid <= 1'b0;
            q_ctrl    <= '0;
            out_pc    <= '0;
            out_instr <= '0;
        end
    end

    // Count bubbles actually inserted; a flush cancels the stall
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (hz && out_ready && !flush && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign out_rd   = out_instr[11:7];
    assign out_rs1  = out_instr[19:15];
    assign out_rs2  = out_instr[24:20];
    assign alusrc   = q_ctrl.alusrc;
    assign memtoreg = q_ctrl.memtoreg;
    assign regwrite = q_ctrl.regwrite;
    assign memwrite = q_ctrl.memwrite;
    assign branch   = q_ctrl.branch;
    assign aluop    = q_ctrl.aluop;
    assign regin    = q_ctrl.regin;
    assign imm      = q_ctrl.imm;
    assign muldiv   = q_ctrl.muldiv;
    assign illegal  = q_ctrl.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: two instances (M enabled with a 2-bit counter,
// M disabled with a 16-bit counter) share one stimulus stream and are
// checked every cycle against an instruction-level model, plus directed
// literal checks of the documented scenarios.
module tb_decode_stage;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        in_valid, flush, out_ready;
    logic [31:0] in_instr, in_pc;

    logic        rdy_a, val_a, rw_a, m2r_a, md_a, ill_a;
    logic [31:0] pc_a, ins_a;
    logic [4:0]  rd_a, rs1_a, rs2_a;
    logic [1:0]  alusrc_a, aluop_a, regin_a;
    logic [3:0]  mw_a;
    logic [2:0]  br_a, imm_a;
    logic [1:0]  cnt_a;

    logic        rdy_b, val_b, rw_b, m2r_b, md_b, ill_b;
    logic [31:0] pc_b, ins_b;
    logic [4:0]  rd_b, rs1_b, rs2_b;
    logic [1:0]  alusrc_b, aluop_b, regin_b;
    logic [3:0]  mw_b;
    logic [2:0]  br_b, imm_b;
    logic [15:0] cnt_b;

    decode_stage #(.XLEN(32), .ENABLE_M(1), .CNT_W(2)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_a),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .out_valid(val_a), .out_ready(out_ready), .out_pc(pc_a),
        .out_instr(ins_a), .out_rd(rd_a), .out_rs1(rs1_a), .out_rs2(rs2_a),
        .alusrc(alusrc_a), .memtoreg(m2r_a), .regwrite(rw_a), .memwrite(mw_a),
        .branch(br_a), .aluop(aluop_a), .regin(regin_a), .imm(imm_a),
        .muldiv(md_a), .illegal(ill_a), .stall_cnt(cnt_a)
    );

    decode_stage #(.XLEN(32), .ENABLE_M(0), .CNT_W(16)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_b),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .out_valid(val_b), .out_ready(out_ready), .out_pc(pc_b),
        .out_instr(ins_b), .out_rd(rd_b), .out_rs1(rs1_b), .out_rs2(rs2_b),
        .alusrc(alusrc_b), .memtoreg(m2r_b), .regwrite(rw_b), .memwrite(mw_b),
        .branch(br_b), .aluop(aluop_b), .regin(regin_b), .imm(imm_b),
        .muldiv(md_b), .illegal(ill_b), .stall_cnt(cnt_b)
    );

    // Actual outputs gathered per instance; ctrl layout
    // {alusrc,memtoreg,regwrite,memwrite,branch,aluop,regin,imm,muldiv,illegal}
    logic [19:0] act_ctrl [2];
    logic [14:0] act_regs [2];
    logic [31:0] act_pc [2], act_ins [2], act_cnt [2];
    logic        act_val [2], act_rdy [2];
    assign act_ctrl[0] = {alusrc_a, m2r_a, rw_a, mw_a, br_a, aluop_a, regin_a, imm_a, md_a, ill_a};
    assign act_ctrl[1] = {alusrc_b, m2r_b, rw_b, mw_b, br_b, aluop_b, regin_b, imm_b, md_b, ill_b};
    assign act_regs[0] = {rd_a, rs1_a, rs2_a};
    assign act_regs[1] = {rd_b, rs1_b, rs2_b};
    assign act_pc[0]   = pc_a;
    assign act_pc[1]   = pc_b;
    assign act_ins[0]  = ins_a;
    assign act_ins[1]  = ins_b;
    assign act_cnt[0]  = {30'd0, cnt_a};
    assign act_cnt[1]  = {16'd0, cnt_b};
    assign act_val[0]  = val_a;
    assign act_val[1]  = val_b;
    assign act_rdy[0]  = rdy_a;
    assign act_rdy[1]  = rdy_b;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The model holds only the instruction sitting in the stage; every
    // output is derived from it through the decode rules.
    bit          en_m [2]  = '{1'b1, 1'b0};
    int          m_max [2] = '{3, 65535};
    bit          m_valid [2];
    logic [31:0] m_pc [2], m_instr [2];
    int          m_stall [2];

    function automatic logic [19:0] mdl_ctrl(input logic [31:0] ins, input bit em);
        logic [1:0] as, ao, ri; logic m2r, rw, md, il; logic [3:0] mw; logic [2:0] br, im;
        logic [2:0] f3;
        f3 = ins[14:12];
        as = 0; ao = 0; ri = 2'b01; m2r = 0; rw = 0; md = 0; il = 0; mw = 0; br = 0; im = 0;
        if (ins[6:0] == 7'h33) begin
            rw = 1; ao = 2;
            if (ins[31:25] == 7'd1) begin if (em) md = 1; else il = 1; end
        end else if (ins[6:0] == 7'h13) begin rw = 1; as = 1; ao = 2;
        end else if (ins[6:0] == 7'h03) begin
            m2r = 1; rw = 1; as = 1; im = (f3 == 4 || f3 == 5) ? 3'd5 : 3'd0;
        end else if (ins[6:0] == 7'h23) begin
            as = 1; im = 1;
            if (f3 == 0) mw = 4'h1; else if (f3 == 1) mw = 4'h3; else if (f3 == 2) mw = 4'hf; else il = 1;
        end else if (ins[6:0] == 7'h63) begin
            ao = 1; im = 4;
            if (f3 == 0 || f3 == 5 || f3 == 7) br = 2;
            else if (f3 == 1 || f3 == 4 || f3 == 6) br = 1;
            else il = 1;
        end else if (ins[6:0] == 7'h6f) begin rw = 1; br = 3; ri = 2; im = 3;
        end else if (ins[6:0] == 7'h67) begin rw = 1; br = 4; ri = 2; as = 1;
        end else if (ins[6:0] == 7'h37) begin rw = 1; ri = 0; im = 2;
        end else if (ins[6:0] == 7'h17) begin rw = 1; as = 3; im = 2;
        end else il = 1;
        if (il) begin rw = 0; mw = 0; br = 0; md = 0; end
        return {as, m2r, rw, mw, br, ao, ri, im, md, il};
    endfunction

    function automatic bit mdl_rs1(input logic [31:0] ins, input bit em);
        logic [19:0] c = mdl_ctrl(ins, em);
        return !c[0] && ins[6:0] != 7'h37 && ins[6:0] != 7'h17 && ins[6:0] != 7'h6f;
    endfunction

    function automatic bit mdl_rs2(input logic [31:0] ins);
        return ins[6:0] == 7'h33 || ins[6:0] == 7'h23 || ins[6:0] == 7'h63;
    endfunction

    function automatic bit mdl_hz(input int i);
        logic [4:0] rd = m_instr[i][11:7];
        logic [19:0] c = mdl_ctrl(m_instr[i], en_m[i]);
        return m_valid[i] && c[17] && rd != 0 && in_valid &&
               ((mdl_rs1(in_instr, en_m[i]) && in_instr[19:15] == rd) ||
                (mdl_rs2(in_instr) && in_instr[24:20] == rd));
    endfunction

    function automatic bit mdl_ready(input int i);
        return !flush && !mdl_hz(i) && (!m_valid[i] || out_ready);
    endfunction

    task automatic mdl_reset();
        for (int i = 0; i < 2; i++) begin
            m_valid[i] = 0; m_pc[i] = 0; m_instr[i] = 0; m_stall[i] = 0;
        end
    endtask

    task automatic mdl_step();
        bit hz [2];
        bit rdy [2];
        for (int i = 0; i < 2; i++) begin
            hz[i] = mdl_hz(i);
            rdy[i] = mdl_ready(i);
        end
        for (int i = 0; i < 2; i++) begin
            if (hz[i] && out_ready && !flush && m_stall[i] < m_max[i]) m_stall[i]++;
            if (flush) m_valid[i] = 0;
            else if (in_valid && rdy[i]) begin
                m_valid[i] = 1; m_pc[i] = in_pc; m_instr[i] = in_instr;
            end else if (out_ready) m_valid[i] = 0;
        end
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("dut%0d valid", i), act_val[i], m_valid[i]);
            chk($sformatf("dut%0d in_ready", i), act_rdy[i], mdl_ready(i));
            chk($sformatf("dut%0d pc", i), act_pc[i], m_valid[i] ? m_pc[i] : 32'd0);
            chk($sformatf("dut%0d instr", i), act_ins[i], m_valid[i] ? m_instr[i] : 32'd0);
            chk($sformatf("dut%0d regs", i), act_regs[i],
                m_valid[i] ? {m_instr[i][11:7], m_instr[i][19:15], m_instr[i][24:20]} : 15'd0);
            chk($sformatf("dut%0d ctrl", i), act_ctrl[i],
                m_valid[i] ? mdl_ctrl(m_instr[i], en_m[i]) : 20'd0);
            chk($sformatf("dut%0d stall_cnt", i), act_cnt[i], m_stall[i]);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic fl, input logic ordy);
        in_valid = v; in_instr = ins; in_pc = pc; flush = fl; out_ready = ordy;
    endtask

    task automatic tick();
        @(posedge clk);
        mdl_step();
        #1;
    endtask

    localparam logic [31:0] I_ADDI = 32'h00500093;  // addi x1,x0,5
    localparam logic [31:0] I_SW   = 32'h00112423;  // sw x1,8(x2)
    localparam logic [31:0] I_LW   = 32'h0000a283;  // lw x5,0(x1)
    localparam logic [31:0] I_ADD  = 32'h00728333;  // add x6,x5,x7
    localparam logic [31:0] I_LW0  = 32'h0000a003;  // lw x0,0(x1)
    localparam logic [31:0] I_ADD0 = 32'h00700333;  // add x6,x0,x7
    localparam logic [31:0] I_JAL  = 32'h010000ef;  // jal x1,16
    localparam logic [31:0] I_MUL  = 32'h023100b3;  // mul x1,x2,x3

    logic [6:0] opc_pool [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
                                   7'h6f, 7'h67, 7'h37, 7'h17, 7'h00};

    initial begin
        logic [31:0] r;
        logic        acc;
        reset = 1'b1;
        drive(0, 0, 0, 0, 1);
        mdl_reset();
        #12;
        chk("reset valid", val_a, 0);
        chk("reset stall", cnt_b, 0);
        chk("reset pc", pc_a, 0);
        reset = 1'b0;

        // back-to-back ADDI / SW
        drive(1, I_ADDI, 32'h100, 0, 1); tick();
        chk("addi valid", val_a, 1); chk("addi regwrite", rw_a, 1);
        chk("addi alusrc", alusrc_a, 2'b01); chk("addi aluop", aluop_a, 2'b10);
        chk("addi rd", rd_a, 1);
        drive(1, I_SW, 32'h104, 0, 1); tick();
        chk("sw valid", val_a, 1); chk("sw memwrite", mw_a, 4'hf);
        chk("sw imm", imm_a, 3'b001); chk("sw alusrc", alusrc_a, 2'b01);
        chk("sw regwrite", rw_a, 0);

        // load-use: one bubble
        drive(1, I_LW, 32'h108, 0, 1); tick();
        chk("lw memtoreg", m2r_a, 1);
        drive(1, I_ADD, 32'h10c, 0, 1); #1;
        chk("hazard in_ready", rdy_a, 0);
        tick();
        chk("bubble valid", val_a, 0); chk("stall a", cnt_a, 1); chk("stall b", cnt_b, 1);
        chk("post-bubble in_ready", rdy_a, 1);
        tick();
        chk("add issue valid", val_a, 1); chk("add issue rd", rd_a, 6); chk("add pc", pc_a, 32'h10c);

        // load to x0: no bubble
        drive(1, I_LW0, 32'h110, 0, 1); tick();
        drive(1, I_ADD0, 32'h114, 0, 1); #1;
        chk("x0 in_ready", rdy_a, 1);
        tick();
        chk("x0 add valid", val_a, 1); chk("x0 add pc", pc_a, 32'h114); chk("x0 stall", cnt_a, 1);

        // JAL held under backpressure
        drive(1, I_JAL, 32'h118, 0, 1); tick();
        chk("jal branch", br_a, 3'b011); chk("jal regin", regin_a, 2'b10);
        drive(1, I_ADDI, 32'h11c, 0, 0);
        for (int k = 0; k < 3; k++) begin
            #1; chk("held in_ready", rdy_a, 0);
            tick();
            chk("held valid", val_a, 1); chk("held branch", br_a, 3'b011);
            chk("held pc", pc_a, 32'h118);
        end
        drive(1, I_ADDI, 32'h11c, 0, 1); tick();
        chk("released pc", pc_a, 32'h11c);

        // flush with a held instruction and a new input
        drive(1, I_SW, 32'h120, 1, 1); #1;
        chk("flush in_ready", rdy_a, 0);
        tick();
        chk("flush valid", val_a, 0);
        drive(0, 0, 0, 0, 1); tick();
        chk("flush drop", val_a, 0);

        // M extension
        drive(1, I_MUL, 32'h124, 0, 1); tick();
        chk("mul muldiv a", md_a, 1); chk("mul aluop a", aluop_a, 2'b10);
        chk("mul illegal a", ill_a, 0); chk("mul illegal b", ill_b, 1);
        chk("mul regwrite b", rw_b, 0); chk("mul muldiv b", md_b, 0);
        drive(1, 32'h0, 32'h128, 0, 1); tick();
        chk("opc0 illegal", ill_a, 1); chk("opc0 regwrite", rw_a, 0);

        // flush during a hazard does not count
        drive(1, I_LW, 32'h12c, 0, 1); tick();
        drive(1, I_ADD, 32'h130, 1, 1); tick();
        chk("flush hz valid", val_a, 0); chk("flush hz stall", cnt_b, 1);

        // saturate the 2-bit counter
        for (int k = 0; k < 4; k++) begin
            drive(1, I_LW, 32'h140 + 8 * k, 0, 1); tick();
            drive(1, I_ADD, 32'h144 + 8 * k, 0, 1); tick(); tick();
        end
        chk("saturated a", cnt_a, 2'd3); chk("count b", cnt_b, 16'd5);

        // asynchronous reset mid-stream
        drive(1, I_ADDI, 32'h200, 0, 1); tick();
        chk("pre-reset valid", val_a, 1);
        #2 reset = 1'b1; mdl_reset();
        #1;
        chk("async valid", val_a, 0); chk("async pc", pc_a, 0); chk("async instr", ins_a, 0);
        chk("async regwrite", rw_a, 0); chk("async stall", cnt_b, 0);
        drive(0, 0, 0, 0, 1);
        #3 reset = 1'b0;

        // randomized stream; a refused input is held until taken or flushed
        drive(0, 0, 32'h1000, 0, 1);
        for (int n = 0; n < 3000; n++) begin
            acc = in_valid && mdl_ready(0);
            if (!in_valid || acc || flush) begin
                r = $urandom;
                r[6:0]   = opc_pool[$urandom_range(0, 9)];
                r[11:7]  = 5'($urandom_range(0, 3));
                r[19:15] = 5'($urandom_range(0, 3));
                r[24:20] = 5'($urandom_range(0, 3));
                case ($urandom_range(0, 2))
                    0: r[31:25] = 7'h00;
                    1: r[31:25] = 7'h20;
                    default: r[31:25] = 7'h01;
                endcase
                in_instr = r;
                in_pc    = in_pc + 4;
                in_valid = ($urandom_range(0, 3) != 0);
            end
            flush     = ($urandom_range(0, 19) == 0);
            out_ready = ($urandom_range(0, 9) < 7);
            tick();
        end

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
